// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the TinyCpu program sequencer.
// Contents: word/field widths, the default idle instruction word, the
// sequencer state enum and helpers that split a program word into its
// data and opcode fields ({data[7:0], opcode[3:0]}).
package tiny_cpu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;
    localparam int WORD_W = DATA_W + OP_W;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [WORD_W-1:0] IDLE_WORD_DEFAULT = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] word_data(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:OP_W];
    endfunction

    function automatic logic [OP_W-1:0] word_opcode(input logic [WORD_W-1:0] w);
        return w[OP_W-1:0];
    endfunction

endpackage

// File: rtl/tiny_prog_mem.sv
// 16 x 12 program store for the sequencer.
// Synchronous write, asynchronous (combinational) read, and an
// asynchronous active-low reset that returns every word to reset_word.
// Ports:
//   clk, clear_n        clock and async active-low reset
//   wr_en/wr_addr/wr_data  write port, lands on the rising edge
//   rd_addr/rd_data     combinational read port
module tiny_prog_mem
    import tiny_cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_WORD = IDLE_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_WORD;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tiny_cpu_sequencer.sv
// Program sequencer in front of the TinyCpu core.
// Holds a 16-word program, issues words 0..Length one per clock while
// running, waits RESULT_LAT cycles after the last word for the CPU to
// settle, then captures Result into FinalResult and pulses Done.
// Ports:
//   Clk, Clear_n              clock, async active-low reset
//   WrEn, WrAddr, WrData      program load port (honoured only in IDLE)
//   Length                    address of the last program word
//   Start, Pause              run control
//   Result                    CPU result register
//   Instr, InstrValid, Pc     registered instruction stream to the CPU
//   Busy, Done, FinalResult   status and captured result
//
// Control handshake: Start is a level sampled only while idle (Busy=0);
// a sampled Start is accepted on that edge and Busy rises with the first
// word. Done is a single-cycle pulse coinciding with Busy falling and the
// FinalResult update; Start may already be high in that same cycle.
module tiny_cpu_sequencer
    import tiny_cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] IDLE_WORD  = IDLE_WORD_DEFAULT,
    parameter int                RESULT_LAT = 2
) (
    input  logic              Clk,
    input  logic              Clear_n,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [WORD_W-1:0] WrData,
    input  logic [ADDR_W-1:0] Length,
    input  logic              Start,
    input  logic              Pause,
    input  logic [DATA_W-1:0] Result,
    output logic [WORD_W-1:0] Instr,
    output logic              InstrValid,
    output logic [ADDR_W-1:0] Pc,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] FinalResult
);

    // The drain counter holds the number of edges still to go before the
    // capture edge. The edge that retires the last word is itself one of
    // the RESULT_LAT edges, so DRAIN is loaded with RESULT_LAT-1 and fires
    // at 1; RESULT_LAT=1 captures directly on that retiring edge.
    localparam logic [2:0] DRAIN_LOAD = 3'(RESULT_LAT - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] instr_d;
    logic              valid_d;
    logic [ADDR_W-1:0] pc_d;
    logic              done_d;
    logic [DATA_W-1:0] final_d;

    logic              mem_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic [WORD_W-1:0] issue_word;

    // Program writes are only honoured while idle.
    assign mem_we  = WrEn && (state_q == ST_IDLE);
    // Idle: next word is word 0. Running: next word is Pc+1.
    assign rd_addr = (state_q == ST_IDLE) ? '0 : Pc + ADDR_W'(1);
    // Write-through bypass so a write coincident with Start is seen by the
    // word issued on that same edge.
    assign issue_word = (mem_we && (WrAddr == rd_addr)) ? WrData : rd_data;

    tiny_prog_mem #(
        .RESET_WORD (IDLE_WORD)
    ) u_mem (
        .clk     (Clk),
        .clear_n (Clear_n),
        .wr_en   (mem_we),
        .wr_addr (WrAddr),
        .wr_data (WrData),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = IDLE_WORD;
        valid_d = 1'b0;
        pc_d    = Pc;
        done_d  = 1'b0;
        final_d = FinalResult;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    instr_d = issue_word;
                    valid_d = 1'b1;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                if (Pause) begin
                    // Hold Pc; the idle word goes out this cycle.
                end else if (Pc >= Length) begin
                    if (RESULT_LAT == 1) begin
                        final_d = Result;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end else begin
                    pc_d    = Pc + ADDR_W'(1);
                    instr_d = issue_word;
                    valid_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 3'd1) begin
                    final_d = Result;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            Instr       <= IDLE_WORD;
            InstrValid  <= 1'b0;
            Pc          <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            FinalResult <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            Instr       <= instr_d;
            InstrValid  <= valid_d;
            Pc          <= pc_d;
            Busy        <= (state_d != ST_IDLE);
            Done        <= done_d;
            FinalResult <= final_d;
        end
    end

endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
// Bench for tiny_cpu_sequencer. Three instances share every input and
// differ only in RESULT_LAT (2, 1, 7). The reference model keeps a copy
// of the program memory and, for each run, builds the expected instruction
// stream as a queue (program words with idle slots inserted for pauses);
// Done/FinalResult timing follows from the run length, pause count and
// latency, with the captured value taken from a log of Result per edge.
module tb_tiny_cpu_sequencer;

    localparam logic [11:0] IDLE_W = 12'h000;
    localparam int LAT [3] = '{2, 1, 7};

    logic        clk = 1'b0;
    logic        clear_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic [3:0]  length;
    logic        start;
    logic        pause;
    logic [7:0]  result;

    logic [11:0] instr_o [3];
    logic        valid_o [3];
    logic [3:0]  pc_o    [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic [7:0]  final_o [3];

    logic [11:0] mem_m [16];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tiny_cpu_sequencer #(.IDLE_WORD(12'h000), .RESULT_LAT(2)) dut (
        .Clk(clk), .Clear_n(clear_n), .WrEn(wr_en), .WrAddr(wr_addr),
        .WrData(wr_data), .Length(length), .Start(start), .Pause(pause),
        .Result(result), .Instr(instr_o[0]), .InstrValid(valid_o[0]),
        .Pc(pc_o[0]), .Busy(busy_o[0]), .Done(done_o[0]), .FinalResult(final_o[0])
    );

    tiny_cpu_sequencer #(.IDLE_WORD(12'h000), .RESULT_LAT(1)) dut_l1 (
        .Clk(clk), .Clear_n(clear_n), .WrEn(wr_en), .WrAddr(wr_addr),
        .WrData(wr_data), .Length(length), .Start(start), .Pause(pause),
        .Result(result), .Instr(instr_o[1]), .InstrValid(valid_o[1]),
        .Pc(pc_o[1]), .Busy(busy_o[1]), .Done(done_o[1]), .FinalResult(final_o[1])
    );

    tiny_cpu_sequencer #(.IDLE_WORD(12'h000), .RESULT_LAT(7)) dut_l7 (
        .Clk(clk), .Clear_n(clear_n), .WrEn(wr_en), .WrAddr(wr_addr),
        .WrData(wr_data), .Length(length), .Start(start), .Pause(pause),
        .Result(result), .Instr(instr_o[2]), .InstrValid(valid_o[2]),
        .Pc(pc_o[2]), .Busy(busy_o[2]), .Done(done_o[2]), .FinalResult(final_o[2])
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s instr[%0d]", tag, k), 16'(instr_o[k]), 16'(IDLE_W));
            check($sformatf("%s valid[%0d]", tag, k), 16'(valid_o[k]), 16'd0);
            check($sformatf("%s pc[%0d]", tag, k), 16'(pc_o[k]), 16'd0);
            check($sformatf("%s busy[%0d]", tag, k), 16'(busy_o[k]), 16'd0);
            check($sformatf("%s done[%0d]", tag, k), 16'(done_o[k]), 16'd0);
            check($sformatf("%s final[%0d]", tag, k), 16'(final_o[k]), 16'd0);
        end
    endtask

    task automatic write_word(input int addr, input logic [11:0] data);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = data;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        mem_m[addr] = data;
    endtask

    task automatic idle(input int cycles);
        start = 1'b0;
        wr_en = 1'b0;
        pause = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    // One program run, entered and left at a negedge. Edge 0 is the Start
    // edge. full=1 follows all three instances to the end of the slowest
    // one; full=0 stops on the cycle the RESULT_LAT=2 instance shows Done.
    task automatic run_prog(input int len, input int pause_at, input int pause_len,
                            input bit full, input bit noise, input bit collide);
        logic [11:0] exp_w[$];
        bit          exp_v[$];
        int          exp_pc[$];
        logic [7:0]  res_hist[$];
        int          npause;
        int          done_n[3];
        int          n_end;
        int          nk;
        logic [11:0] ew;
        bit          ev;
        int          ep;

        if (collide) mem_m[0] = 12'h777;
        npause = (pause_at <= len) ? pause_len : 0;
        for (int i = 0; i <= len; i++) begin
            exp_w.push_back(mem_m[i]);
            exp_v.push_back(1'b1);
            exp_pc.push_back(i);
            if (i == pause_at) begin
                for (int p = 0; p < npause; p++) begin
                    exp_w.push_back(IDLE_W);
                    exp_v.push_back(1'b0);
                    exp_pc.push_back(i);
                end
            end
        end
        for (int k = 0; k < 3; k++) done_n[k] = len + npause + LAT[k];
        n_end = full ? done_n[2] : done_n[0];
        nk    = full ? 3 : 1;

        length  = 4'(len);
        start   = 1'b1;
        pause   = 1'($urandom_range(0, 1));
        wr_en   = collide;
        wr_addr = 4'd0;
        wr_data = 12'h777;
        result  = 8'($urandom);
        res_hist.push_back(result);

        for (int n = 0; n <= n_end; n++) begin
            @(posedge clk);
            @(negedge clk);
            ew = (n < exp_w.size()) ? exp_w[n] : IDLE_W;
            ev = (n < exp_w.size()) ? exp_v[n] : 1'b0;
            ep = (n < exp_w.size()) ? exp_pc[n] : len;
            for (int k = 0; k < nk; k++) begin
                check($sformatf("instr[%0d] n=%0d", k, n), 16'(instr_o[k]), 16'(ew));
                check($sformatf("valid[%0d] n=%0d", k, n), 16'(valid_o[k]), 16'(ev));
                check($sformatf("pc[%0d] n=%0d", k, n), 16'(pc_o[k]), 16'(ep));
                check($sformatf("busy[%0d] n=%0d", k, n), 16'(busy_o[k]), 16'(n < done_n[k]));
                check($sformatf("done[%0d] n=%0d", k, n), 16'(done_o[k]), 16'(n == done_n[k]));
                if (n == done_n[k])
                    check($sformatf("final[%0d] n=%0d", k, n), 16'(final_o[k]), 16'(res_hist[n]));
            end
            // Inputs for edge n+1.
            start   = noise && (n < 2);
            wr_en   = noise && (n < 2);
            wr_addr = 4'd1;
            wr_data = 12'($urandom);
            if ((n + 1 > pause_at) && (n + 1 <= pause_at + npause))
                pause = 1'b1;
            else if (n + 1 > len + npause + 1)
                pause = 1'($urandom_range(0, 1));
            else
                pause = 1'b0;
            result = 8'($urandom);
            res_hist.push_back(result);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        clear_n = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        length  = '0;
        start   = 1'b0;
        pause   = 1'b0;
        result  = '0;
        for (int i = 0; i < 16; i++) mem_m[i] = IDLE_W;

        // Reset state.
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        clear_n = 1'b1;
        @(negedge clk);

        // Basic run.
        write_word(0, 12'hA51);
        write_word(1, 12'h3C2);
        write_word(2, 12'h0F3);
        run_prog(2, 99, 0, 1'b1, 1'b0, 1'b0);

        // Two pause cycles after word 1.
        run_prog(2, 1, 2, 1'b1, 1'b0, 1'b0);

        // Single word, all three latencies.
        run_prog(0, 99, 0, 1'b1, 1'b0, 1'b0);

        // Writes and Start while busy are ignored; rerun shows mem[1] intact.
        write_word(3, 12'($urandom));
        write_word(4, 12'($urandom));
        run_prog(4, 99, 0, 1'b1, 1'b1, 1'b0);
        run_prog(4, 99, 0, 1'b1, 1'b0, 1'b0);

        // Write to address 0 coincident with Start.
        run_prog(4, 99, 0, 1'b1, 1'b0, 1'b1);

        // Back-to-back: second Start while Done is high.
        run_prog(3, 1, 1, 1'b0, 1'b0, 1'b0);
        run_prog(3, 99, 0, 1'b0, 1'b0, 1'b0);
        idle(12);

        // Randomized programs, lengths and pauses.
        for (int r = 0; r < 6; r++) begin
            int len;
            for (int a = 0; a < 16; a++) write_word(a, 12'($urandom));
            len = $urandom_range(0, 15);
            run_prog(len, $urandom_range(0, len + 2), $urandom_range(0, 3),
                     1'b1, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a run.
        length = 4'd5;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 clear_n = 1'b0;
        #1 check_reset_values("midrun");
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < 16; i++) mem_m[i] = IDLE_W;
        @(negedge clk);
        // Memory must have returned to the idle word.
        run_prog(5, 99, 0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
